// File: rtl/fmul_ctrl.sv
// Issue/capture controller for the handshake-free FP multiplier fmul: holds operands LAT cycles, then presents y.
// Optional zero-operand bypass is enabled by defining FMUL_ZERO_BYPASS_EN.
module fmul_ctrl #(
    parameter int LAT   = 3,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic [31:0]      mul_x1,
    output logic [31:0]      mul_x2,
    input  logic [31:0]      mul_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int CW = $clog2(LAT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [TAG_W-1:0] tag;
    logic             accept;
    logic             zero_op;

    // Handshakes: a transfer happens on a clock edge where valid && ready are both high;
    // once valid is raised the payload is held until that edge. A result leaving RESP frees
    // the controller on the same edge, so a waiting request is taken with no bubble.
    assign in_ready = (state == IDLE) || (state == RESP && out_ready);
    assign accept   = in_valid && in_ready;
    assign busy     = (state != IDLE);

`ifdef FMUL_ZERO_BYPASS_EN
    assign zero_op = (in_a[30:0] == 31'd0) || (in_b[30:0] == 31'd0);
`else
    assign zero_op = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            cnt       <= '0;
            tag       <= '0;
            mul_x1    <= '0;
            mul_x2    <= '0;
            out_data  <= '0;
            out_tag   <= '0;
            out_valid <= 1'b0;
        end else if (state == WAIT) begin
            // Operands stay frozen here; fmul takes some result fields straight from its inputs.
            if (cnt != '0) begin
                cnt <= cnt - CW'(1);
            end else begin
                out_data  <= mul_y;
                out_tag   <= tag;
                out_valid <= 1'b1;
                state     <= RESP;
            end
        end else if (accept) begin
            mul_x1 <= in_a;
            mul_x2 <= in_b;
            tag    <= in_tag;
            cnt    <= CW'(LAT);
            if (zero_op) begin
                out_data  <= {in_a[31] ^ in_b[31], 31'd0};
                out_tag   <= in_tag;
                out_valid <= 1'b1;
                state     <= RESP;
            end else begin
                out_valid <= 1'b0;
                state     <= WAIT;
            end
        end else if (state == RESP && out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
        end
    end

endmodule

// File: tb/tb_fmul_ctrl.sv
// Bench for fmul_ctrl: behavioural fmul environment, directed steps, then 100 random ops with a scoreboard.
// Zero-operand latency expectations follow FMUL_ZERO_BYPASS_EN.
module tb_fmul_ctrl;

    localparam int LAT   = 3;
    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_a = '0;
    logic [31:0]      in_b = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic [31:0]      mul_x1;
    logic [31:0]      mul_x2;
    logic [31:0]      mul_y;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    logic dir_ready = 1'b1;
    logic rand_ready = 1'b1;
    logic rand_phase = 1'b0;
    assign out_ready = rand_phase ? rand_ready : dir_ready;

    int total = 0;
    int bad = 0;
    logic [TAG_W+31:0] exp_q[$];

    fmul_ctrl #(.LAT(LAT), .TAG_W(TAG_W)) dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .mul_x1(mul_x1), .mul_x2(mul_x2), .mul_y(mul_y),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag),
        .busy(busy)
    );

    // clock/reset
    always #5 clk = ~clk;

    // Reference product for normal numbers (truncating); zero operands give a signed zero.
    function automatic logic [31:0] fmul_model(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        logic [47:0] m;
        logic [9:0]  e;
        logic [22:0] f;
        s = a[31] ^ b[31];
        if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return {s, 31'd0};
        m = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
        if (m[47]) begin
            f = m[46:24];
            e = e + 10'd1;
        end else begin
            f = m[45:23];
        end
        return {s, e[7:0], f};
    endfunction

    // fmul itself: LAT-edge pipeline sampling whatever sits on x1/x2.
    logic [31:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= fmul_model(mul_x1, mul_x2);
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mul_y = pipe[LAT-1];

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // scoreboard: push expected on accept, compare on result transfer
    always @(posedge clk) begin
        if (rstn) begin
            if (in_valid && in_ready)
                exp_q.push_back({in_tag, fmul_model(in_a, in_b)});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 64'(out_data), 64'hDEAD);
                end else begin
                    check("sb_result", 64'({out_tag, out_data}), 64'(exp_q.pop_front()));
                end
            end
        end
    end

    // operand stability: busy && !out_valid is exactly the waiting period
    logic        prev_wait = 1'b0;
    logic [31:0] px1 = '0;
    logic [31:0] px2 = '0;
    always @(negedge clk) begin
        logic cur_wait;
        cur_wait = rstn && busy && !out_valid;
        if (cur_wait && prev_wait) begin
            check("x1_stable", 64'(mul_x1), 64'(px1));
            check("x2_stable", 64'(mul_x2), 64'(px2));
        end
        prev_wait = cur_wait;
        px1 = mul_x1;
        px2 = mul_x2;
    end

    always @(negedge clk) rand_ready = 1'($urandom_range(0, 1));

    // driver tasks: called and returning at posedge+1
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] t);
        int n;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_tag = t;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) check("issue_timeout", 64'(n), 64'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // number of edges after the accept edge until out_valid is seen
    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int n;
        int seen;
        logic [31:0] ra, rb;

        // reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_mul_x1", 64'(mul_x1), 64'd0);
        check("rst_mul_x2", 64'(mul_x2), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rstn = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // single op: 2.0 * 3.0
        dir_ready = 1'b1;
        issue(32'h40000000, 32'h40400000, 5'd7);
        check("single_busy", 64'(busy), 64'd1);
        check("single_in_ready_wait", 64'(in_ready), 64'd0);
        check("single_x1", 64'(mul_x1), 64'h40000000);
        wait_result(lat);
        check("single_latency", 64'(lat), 64'(LAT + 1));
        check("single_data", 64'(out_data), 64'h40C00000);
        check("single_tag", 64'(out_tag), 64'd7);
        @(posedge clk); #1;
        check("single_pulse", 64'(out_valid), 64'd0);
        check("single_idle", 64'(busy), 64'd0);
        check("single_in_ready", 64'(in_ready), 64'd1);

        // backpressure: 1.0 * -1.0 held for 6 cycles while another request waits
        dir_ready = 1'b0;
        issue(32'h3F800000, 32'hBF800000, 5'd2);
        wait_result(lat);
        check("bp_latency", 64'(lat), 64'(LAT + 1));
        in_valid = 1'b1;
        in_a = 32'h41000000;
        in_b = 32'h41000000;
        in_tag = 5'd30;
        for (int i = 0; i < 6; i++) begin
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_data", 64'(out_data), 64'hBF800000);
            check("bp_tag", 64'(out_tag), 64'd2);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        dir_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release", 64'(out_valid), 64'd0);
        check("bp_not_accepted", 64'(busy), 64'd0);

        // back-to-back through RESP
        issue(32'h40000000, 32'h40000000, 5'd1);
        wait_result(lat);
        check("b2b_first_data", 64'(out_data), 64'h40800000);
        check("b2b_first_tag", 64'(out_tag), 64'd1);
        in_valid = 1'b1;
        in_a = 32'h40800000;
        in_b = 32'h3F000000;
        in_tag = 5'd3;
        check("b2b_in_ready_resp", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("b2b_reissued", 64'(busy), 64'd1);
        check("b2b_valid_drop", 64'(out_valid), 64'd0);
        wait_result(lat);
        check("b2b_latency", 64'(lat), 64'(LAT + 1));
        check("b2b_data", 64'(out_data), 64'h40000000);
        check("b2b_tag", 64'(out_tag), 64'd3);
        @(posedge clk); #1;

        // zero operand: -0.0 * 5.0
        issue(32'h80000000, 32'h40A00000, 5'd9);
        wait_result(lat);
`ifdef FMUL_ZERO_BYPASS_EN
        // result already registered on the accept edge
        check("zero_latency", 64'(lat), 64'd0);
`else
        check("zero_latency", 64'(lat), 64'(LAT + 1));
`endif
        check("zero_data", 64'(out_data), 64'h80000000);
        check("zero_sign", 64'(out_data[31]), 64'd1);
        check("zero_tag", 64'(out_tag), 64'd9);
        check("zero_x1_loaded", 64'(mul_x1), 64'h80000000);
        @(posedge clk); #1;

        // reset mid-op
        issue(32'h3FC00000, 32'h40000000, 5'd4);
        repeat (2) begin
            @(posedge clk); #1;
        end
        rstn = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_x1", 64'(mul_x1), 64'd0);
        check("mid_rst_x2", 64'(mul_x2), 64'd0);
        exp_q.delete();
        @(negedge clk);
        rstn = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("mid_rst_no_stale", 64'(seen), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);

        // random ops with random out_ready; the scoreboard and stability checker do the work
        rand_phase = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            ra = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 23'($urandom)};
            rb = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 23'($urandom)};
            if ($urandom_range(0, 7) == 0) ra[30:0] = 31'd0;
            in_valid = 1'b1;
            in_a = ra;
            in_b = rb;
            in_tag = TAG_W'($urandom);
            n = 0;
            do begin
                @(posedge clk);
                seen = int'(in_ready);
                n++;
            end while (seen == 0 && n < 200);
            if (seen == 0) check("rand_accept_timeout", 64'(n), 64'd0);
            @(negedge clk);
            in_valid = 1'b0;
        end
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check("rand_drained", 64'(exp_q.size()), 64'd0);
        check("rand_idle", 64'(busy), 64'd0);
        rand_phase = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
